input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//  Multi-channel synchroniser and debounce filter for raw asynchronous inputs (buttons, external strobes).
//  Sits directly upstream of the edge detector: each sig_out bit drives one edge detector's signal_inp.
//  Downstream p_edge/n_edge pulses are therefore glitch-free and metastability-safe.
//  Filtering is counter-based: an output changes only after the synchronised input holds a new level for N ticks.
// PARAMETERS
//  WIDTH            4   number of independent channels
//  SYNC_STAGES      2   flops in each synchroniser chain; legal range 2..4
//  DEBOUNCE_CYCLES  16  consecutive qualifying ticks before sig_out flips; legal range >= 1
//  RESET_VAL        0   reset level of every sig_out bit and every synchroniser flop (1-bit value, same for all channels)
//  CNT_W            derived, $clog2(DEBOUNCE_CYCLES+1); not overridable
// PORTS
//  clk          in   1      system clock; all flops rising-edge
//  rst          in   1      asynchronous, active-low reset (asserts immediately, releases on clk)
//  tick         in   1      sample strobe from the shared prescaler; tie to 1 to count every clk
//  sig_in       in   WIDTH  raw asynchronous inputs
//  sig_out      out  WIDTH  debounced, synchronised levels
//  sig_changed  out  WIDTH  one-clk pulse in the cycle after sig_out[i] flips
//  busy         out  1      OR over channels of (cnt[i] != 0)
//  glitch_cnt   out  8      only with DEBOUNCE_GLITCH_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0): sync chains=RESET_VAL, sig_out={WIDTH{RESET_VAL}}, cnt=0, sig_changed=0, busy=0, glitch_cnt=0.
//  Per channel i, s = last synchroniser stage, out = sig_out[i]; two states, STABLE (cnt==0) and PENDING (cnt!=0):
//   - s == out (any tick): cnt <= 0; back to STABLE; out held.
//   - s != out, tick=0: cnt held; out held.
//   - s != out, tick=1, cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1 (enters or stays PENDING).
//   - s != out, tick=1, cnt == DEBOUNCE_CYCLES-1: out <= s; cnt <= 0; sig_changed[i] <= 1.
//  sig_changed[i] is registered: high exactly one clk, in the cycle after out flips; 0 otherwise.
//  Latency (tick=1): sig_in stable from capturing edge k -> sig_out flips at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
//  DEBOUNCE_CYCLES=1: flip on the first tick with s != out (pure synchroniser plus one register).
//  Bounce: any return of s to out before the count completes clears cnt; restart needs a full DEBOUNCE_CYCLES run.
//  tick gaps: cnt never decays while tick=0; only s == out clears it.
//  Channels are fully independent; simultaneous flips on several channels are legal in the same cycle.
//  cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
//  Reset mid-count: all state returns to reset values asynchronously; no sig_changed pulse results from reset.
//  busy is combinational from cnt registers only (no path from sig_in).
// CONFIGURATION
//  `DEBOUNCE_GLITCH_CNT_EN defined:
//   - glitch_cnt port exists.
//   - Increments by 1 per clk on which at least one channel goes PENDING -> STABLE without flipping
//     (s returns to out while cnt != 0).
//   - Several channels aborting in the same clk count as 1. Saturates at 8'hFF; cleared only by reset.
//  Not defined: glitch_cnt port and its logic are absent. All other behaviour is identical.
// TESTING
//  1 Reset: rst=0 with sig_in=4'hF toggling -> sig_out=0, sig_changed=0, busy=0; after release, no spurious pulse.
//  2 Clean edge (tick=1, N=16, SYNC=2): sig_in[0] 0->1 at edge 10 -> sig_out[0]=1 after edge 27,
//    sig_changed[0]=1 only in the following cycle.
//  3 Bounce: sig_in[1] high 5 clks, low 3, high 20 -> no flip from the first burst;
//    flip 17 edges after the final rise; glitch_cnt=1 when the macro is enabled.
//  4 Tick gating: tick every 4th clk, N=16 -> flip only after the 16th qualifying tick;
//    cnt holds through tick=0 cycles.
//  5 Simultaneous: sig_in 4'h0->4'hF in one cycle -> all four sig_out bits and sig_changed bits assert
//    on the same edges; busy=1 throughout the count.
//  6 Mid-count reset: rst pulsed low at cnt=9 -> sig_out=0, cnt=0, busy=0 immediately;
//    after release a full 16-tick run is required to flip.

Source files
------------

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw-input source and the input_debouncer.
//   master : drives tick and sig_in, observes the filtered results
//   slave  : the debouncer itself
// Ports carried:
//   tick        sample strobe from the shared prescaler
//   sig_in      raw asynchronous inputs, WIDTH bits
//   sig_out     debounced, synchronised levels
//   sig_changed one-clk pulse in the cycle after sig_out[i] flips
//   busy        some channel has a debounce count in progress
//   glitch_cnt  saturating abort counter (only with DEBOUNCE_GLITCH_CNT_EN)
interface input_debouncer_if #(
   parameter int WIDTH = 4
);
   logic             tick;
   logic [WIDTH-1:0] sig_in;
   logic [WIDTH-1:0] sig_out;
   logic [WIDTH-1:0] sig_changed;
   logic             busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0]       glitch_cnt;

   modport master (output tick, sig_in,
                   input  sig_out, sig_changed, busy, glitch_cnt);
   modport slave  (input  tick, sig_in,
                   output sig_out, sig_changed, busy, glitch_cnt);
`else
   modport master (output tick, sig_in,
                   input  sig_out, sig_changed, busy);
   modport slave  (input  tick, sig_in,
                   output sig_out, sig_changed, busy);
`endif
endinterface

// File: rtl/input_debouncer.sv
// Multi-channel synchroniser and counter-based debounce filter for raw
// asynchronous inputs. Each channel passes through a SYNC_STAGES flop chain;
// sig_out[i] only follows the synchronised level after it has differed from
// sig_out[i] for DEBOUNCE_CYCLES consecutive ticks.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  input_debouncer_if.slave (tick, sig_in, sig_out, sig_changed, busy,
//        glitch_cnt)
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds the 8-bit saturating
// glitch_cnt, counting clocks on which any channel aborts a pending count.
//
// Per-channel state (encoded by the counter, no separate state register):
//   state   | meaning
//   STABLE  | cnt == 0, synchronised input equals sig_out
//   PENDING | cnt != 0, synchronised input differs, counting qualifying ticks
module input_debouncer #(
   parameter int   WIDTH           = 4,
   parameter int   SYNC_STAGES     = 2,   // 2..4
   parameter int   DEBOUNCE_CYCLES = 16,  // >= 1
   parameter logic RESET_VAL       = 1'b0
) (
   input logic               clk,
   input logic               rst,
   input_debouncer_if.slave  bus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_q;
   logic [WIDTH-1:0][CNT_W-1:0]       cnt_q;
   logic [WIDTH-1:0]                  out_q;
   logic [WIDTH-1:0]                  chg_q;
   logic [WIDTH-1:0]                  s_w;
   logic [WIDTH-1:0]                  abort_w;
   logic                              busy_w;

   always_comb begin
      s_w     = '0;
      abort_w = '0;
      busy_w  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         s_w[i]     = sync_q[i][SYNC_STAGES-1];
         // Pending count dropped because the input went back before completion.
         abort_w[i] = (s_w[i] == out_q[i]) && (cnt_q[i] != '0);
         busy_w     = busy_w | (cnt_q[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {(WIDTH*SYNC_STAGES){RESET_VAL}};
         cnt_q  <= '0;
         out_q  <= {WIDTH{RESET_VAL}};
         chg_q  <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.sig_in[i]};
            chg_q[i]  <= 1'b0;
            if (s_w[i] == out_q[i]) begin
               cnt_q[i] <= '0;
            end else if (bus.tick) begin
               if (cnt_q[i] == CNT_LAST) begin
                  out_q[i] <= s_w[i];
                  cnt_q[i] <= '0;
                  chg_q[i] <= 1'b1;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end
         end
      end
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_q;

   // Simultaneous aborts on several channels count once; saturates at 8'hFF.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         glitch_q <= 8'h00;
      end else if ((|abort_w) && (glitch_q != 8'hFF)) begin
         glitch_q <= glitch_q + 8'd1;
      end
   end

   assign bus.glitch_cnt = glitch_q;
`endif

   assign bus.sig_out     = out_q;
   assign bus.sig_changed = chg_q;
   assign bus.busy        = busy_w;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   input_debouncer_if #(.WIDTH(4)) dif ();

   input_debouncer #(
      .WIDTH(4),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(16),
      .RESET_VAL(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are observed 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      dif.tick   = 1'b1;
      dif.sig_in = 4'hF;
      rst        = 1'b1;
      #2;
      rst = 1'b0;
      for (int j = 0; j < 6; j++) begin
         step();
         dif.sig_in = ~dif.sig_in;
         checks++;
         if (dif.sig_out !== 4'h0 || dif.sig_changed !== 4'h0 || dif.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: sig_out=%h chg=%h busy=%b required 0/0/0",
                     dif.sig_out, dif.sig_changed, dif.busy);
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (dif.glitch_cnt !== 8'h00) begin
         failures++;
         $display("FAIL reset_glitch: got %h required 00", dif.glitch_cnt);
      end
`endif
      dif.sig_in = 4'h0;
      rst        = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         step();
         checks++;
         if (dif.sig_out !== 4'h0 || dif.sig_changed !== 4'h0) begin
            failures++;
            $display("FAIL reset_release j=%0d: sig_out=%h chg=%h required 0/0",
                     j, dif.sig_out, dif.sig_changed);
         end
      end
   endtask

   task automatic test_clean_edge();
      logic [3:0] e_out, e_chg;
      logic       e_busy;
      dif.sig_in = 4'h1;
      for (int j = 1; j <= 20; j++) begin
         step();
         e_out  = (j >= 18) ? 4'h1 : 4'h0;
         e_chg  = (j == 18) ? 4'h1 : 4'h0;
         e_busy = (j >= 3 && j <= 17);
         checks++;
         if (dif.sig_out !== e_out || dif.sig_changed !== e_chg || dif.busy !== e_busy) begin
            failures++;
            $display("FAIL clean_edge j=%0d: out=%h chg=%h busy=%b required %h/%h/%b",
                     j, dif.sig_out, dif.sig_changed, dif.busy, e_out, e_chg, e_busy);
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] e_out, e_chg;
      dif.sig_in = 4'h3;
      for (int j = 1; j <= 5; j++) begin
         step();
         checks++;
         if (dif.sig_out !== 4'h1) begin
            failures++;
            $display("FAIL bounce_burst j=%0d: out=%h required 1", j, dif.sig_out);
         end
      end
      dif.sig_in = 4'h1;
      for (int j = 1; j <= 3; j++) step();
      checks++;
      if (dif.sig_out !== 4'h1 || dif.busy !== 1'b0) begin
         failures++;
         $display("FAIL bounce_abort: out=%h busy=%b required 1/0", dif.sig_out, dif.busy);
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (dif.glitch_cnt !== 8'h01) begin
         failures++;
         $display("FAIL bounce_glitch: got %h required 01", dif.glitch_cnt);
      end
`endif
      dif.sig_in = 4'h3;
      for (int j = 1; j <= 20; j++) begin
         step();
         e_out = (j >= 18) ? 4'h3 : 4'h1;
         e_chg = (j == 18) ? 4'h2 : 4'h0;
         checks++;
         if (dif.sig_out !== e_out || dif.sig_changed !== e_chg) begin
            failures++;
            $display("FAIL bounce_final j=%0d: out=%h chg=%h required %h/%h",
                     j, dif.sig_out, dif.sig_changed, e_out, e_chg);
         end
      end
   endtask

   task automatic test_tick_gating();
      logic [3:0] e_out, e_chg;
      logic       e_busy;
      dif.tick   = 1'b0;
      dif.sig_in = 4'h7;
      for (int j = 1; j <= 3; j++) step();
      checks++;
      if (dif.busy !== 1'b0 || dif.sig_out !== 4'h3) begin
         failures++;
         $display("FAIL tick_idle: busy=%b out=%h required 0/3", dif.busy, dif.sig_out);
      end
      for (int q = 1; q <= 16; q++) begin
         dif.tick = 1'b1;
         step();
         dif.tick = 1'b0;
         e_out  = (q == 16) ? 4'h7 : 4'h3;
         e_chg  = (q == 16) ? 4'h4 : 4'h0;
         e_busy = (q < 16);
         checks++;
         if (dif.sig_out !== e_out || dif.sig_changed !== e_chg || dif.busy !== e_busy) begin
            failures++;
            $display("FAIL tick_edge q=%0d: out=%h chg=%h busy=%b required %h/%h/%b",
                     q, dif.sig_out, dif.sig_changed, dif.busy, e_out, e_chg, e_busy);
         end
         for (int r = 1; r <= 3; r++) begin
            step();
            checks++;
            if (dif.sig_out !== e_out || dif.sig_changed !== 4'h0 || dif.busy !== e_busy) begin
               failures++;
               $display("FAIL tick_gap q=%0d r=%0d: out=%h chg=%h busy=%b required %h/0/%b",
                        q, r, dif.sig_out, dif.sig_changed, dif.busy, e_out, e_busy);
            end
         end
      end
      dif.tick = 1'b1;
   endtask

   task automatic test_simultaneous();
      logic [3:0] e_out, e_chg;
      logic       e_busy;
      dif.sig_in = 4'h0;
      for (int j = 1; j <= 20; j++) begin
         step();
         e_out = (j >= 18) ? 4'h0 : 4'h7;
         e_chg = (j == 18) ? 4'h7 : 4'h0;
         checks++;
         if (dif.sig_out !== e_out || dif.sig_changed !== e_chg) begin
            failures++;
            $display("FAIL simul_fall j=%0d: out=%h chg=%h required %h/%h",
                     j, dif.sig_out, dif.sig_changed, e_out, e_chg);
         end
      end
      dif.sig_in = 4'hF;
      for (int j = 1; j <= 20; j++) begin
         step();
         e_out  = (j >= 18) ? 4'hF : 4'h0;
         e_chg  = (j == 18) ? 4'hF : 4'h0;
         e_busy = (j >= 3 && j <= 17);
         checks++;
         if (dif.sig_out !== e_out || dif.sig_changed !== e_chg || dif.busy !== e_busy) begin
            failures++;
            $display("FAIL simul_rise j=%0d: out=%h chg=%h busy=%b required %h/%h/%b",
                     j, dif.sig_out, dif.sig_changed, dif.busy, e_out, e_chg, e_busy);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] e_out, e_chg;
      dif.sig_in = 4'h0;
      for (int j = 1; j <= 11; j++) step();
      checks++;
      if (dif.busy !== 1'b1 || dif.sig_out !== 4'hF) begin
         failures++;
         $display("FAIL midrst_pre: busy=%b out=%h required 1/f", dif.busy, dif.sig_out);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (dif.sig_out !== 4'h0 || dif.busy !== 1'b0 || dif.sig_changed !== 4'h0) begin
         failures++;
         $display("FAIL midrst_async: out=%h busy=%b chg=%h required 0/0/0",
                  dif.sig_out, dif.busy, dif.sig_changed);
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (dif.glitch_cnt !== 8'h00) begin
         failures++;
         $display("FAIL midrst_glitch: got %h required 00", dif.glitch_cnt);
      end
`endif
      step();
      step();
      dif.sig_in = 4'hF;
      rst        = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         step();
         e_out = (j >= 18) ? 4'hF : 4'h0;
         e_chg = (j == 18) ? 4'hF : 4'h0;
         checks++;
         if (dif.sig_out !== e_out || dif.sig_changed !== e_chg) begin
            failures++;
            $display("FAIL midrst_rerun j=%0d: out=%h chg=%h required %h/%h",
                     j, dif.sig_out, dif.sig_changed, e_out, e_chg);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_clean_edge();
      test_bounce();
      test_tick_gating();
      test_simultaneous();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
